// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between an instruction-fetch port (I) and a
//   data load/store port (D). Only one transaction is in flight at a time.
//   Simultaneous requests alternate: the port not granted last wins the tie.
//   A transaction that receives no MemAck within TIMEOUT busy cycles is
//   aborted. The owning port still gets its Valid pulse, with zero data, and
//   the sticky MemErr flag is set.
//
// Ports
//   CLK, RST                          clock, async active-high reset
//   IReq, IAddr                       fetch request/address (held until IValid)
//   DReq, DWE, DAddr, DWData          data request (held until DValid)
//   MemReq, MemWE, MemAddr, MemWData  registered memory request
//   MemRData, MemAck                  memory read data, completion strobe
//   IRData, IValid                    fetch data, one-cycle completion pulse
//   DRData, DValid                    load data (0 for stores), completion pulse
//   Stall                             a request is pending and its Valid is low
//   MemErr                            sticky timeout flag
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  input  logic              DReq,
  input  logic              DWE,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  output logic              MemReq,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemAck,
  output logic [DATA_W-1:0] IRData,
  output logic              IValid,
  output logic [DATA_W-1:0] DRData,
  output logic              DValid,
  output logic              Stall,
  output logic              MemErr
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_d;   // 1: D was granted last, 0: I (reset value)
  logic             w_grant_i;
  logic             w_grant_d;
  logic             w_done;
  logic             w_timeout;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      IDLE: begin
        // MemAck is deliberately ignored here
        if (DReq && (!IReq || !r_last_d)) begin
          w_grant_d   = 1'b1;
          w_state_nxt = D_BUSY;
        end else if (IReq) begin
          w_grant_i   = 1'b1;
          w_state_nxt = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        // An ack on the cycle the counter would reach TIMEOUT wins over the abort
        if (MemAck)                                w_done    = 1'b1;
        else if (r_cnt == CNT_W'(TIMEOUT - 1))     w_timeout = 1'b1;
        if (w_done || w_timeout) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MemReq   <= 1'b0;
      MemWE    <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      IRData   <= '0;
      IValid   <= 1'b0;
      DRData   <= '0;
      DValid   <= 1'b0;
      MemErr   <= 1'b0;
      r_cnt    <= '0;
      r_last_d <= 1'b0;
    end else begin
      IValid <= 1'b0;
      DValid <= 1'b0;
      if (w_grant_d) begin
        MemReq   <= 1'b1;
        MemWE    <= DWE;
        MemAddr  <= DAddr;
        MemWData <= DWData;
        r_cnt    <= '0;
        r_last_d <= 1'b1;
      end else if (w_grant_i) begin
        MemReq   <= 1'b1;
        MemWE    <= 1'b0;
        MemAddr  <= IAddr;
        r_cnt    <= '0;
        r_last_d <= 1'b0;
      end else if (w_done || w_timeout) begin
        MemReq <= 1'b0;
        MemWE  <= 1'b0;
        if (r_state == I_BUSY) begin
          IValid <= 1'b1;
          IRData <= w_done ? MemRData : '0;
        end else begin
          DValid <= 1'b1;
          DRData <= (w_done && !MemWE) ? MemRData : '0;
        end
        if (w_timeout) MemErr <= 1'b1;
      end else if (r_state != IDLE) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign Stall = (IReq & ~IValid) | (DReq & ~DValid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          CLK;
  logic          RST;
  logic          IReq;
  logic [AW-1:0] IAddr;
  logic          DReq;
  logic          DWE;
  logic [AW-1:0] DAddr;
  logic [DW-1:0] DWData;
  logic          MemReq;
  logic          MemWE;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData;
  logic [DW-1:0] MemRData;
  logic          MemAck;
  logic [DW-1:0] IRData;
  logic          IValid;
  logic [DW-1:0] DRData;
  logic          DValid;
  logic          Stall;
  logic          MemErr;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .IReq(IReq), .IAddr(IAddr),
    .DReq(DReq), .DWE(DWE), .DAddr(DAddr), .DWData(DWData),
    .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck),
    .IRData(IRData), .IValid(IValid),
    .DRData(DRData), .DValid(DValid),
    .Stall(Stall), .MemErr(MemErr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    IReq = 0; IAddr = '0; DReq = 0; DWE = 0; DAddr = '0; DWData = '0;
    MemAck = 0; MemRData = '0;
  endtask

  task automatic do_reset();
    step();
    clear_inputs();
    RST = 1;
    step();
    RST = 0;
  endtask

  // Reset is asserted before the first clock edge; outputs must clear without CLK.
  task automatic test_reset();
    clear_inputs();
    RST = 1;
    #2;
    total++; if ({MemReq, MemWE, IValid, DValid, MemErr} !== 5'b0) begin bad++; $display("FAIL rst_ctrl: got %b want 00000", {MemReq, MemWE, IValid, DValid, MemErr}); end
    total++; if (MemAddr !== '0 || MemWData !== '0) begin bad++; $display("FAIL rst_mem: got %h/%h want 0/0", MemAddr, MemWData); end
    total++; if (IRData !== '0 || DRData !== '0) begin bad++; $display("FAIL rst_rdata: got %h/%h want 0/0", IRData, DRData); end
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", Stall); end
    step();
    RST = 0;
  endtask

  task automatic test_ack_idle();
    MemAck = 1; MemRData = 32'hDEAD_BEEF;
    step();
    step();
    MemAck = 0;
    total++; if ({MemReq, IValid, DValid, MemErr} !== 4'b0) begin bad++; $display("FAIL ackidle_ctrl: got %b want 0000", {MemReq, IValid, DValid, MemErr}); end
    total++; if (IRData !== '0 || DRData !== '0) begin bad++; $display("FAIL ackidle_rdata: got %h/%h want 0/0", IRData, DRData); end
  endtask

  task automatic test_ifetch();
    logic ok;
    IReq = 1; IAddr = 32'h0000_0010;
    step();
    total++; if (MemReq !== 1 || MemWE !== 0 || MemAddr !== 32'h10) begin bad++; $display("FAIL if_req: got %b%b %h want 10 00000010", MemReq, MemWE, MemAddr); end
    total++; if (Stall !== 1) begin bad++; $display("FAIL if_stall_busy: got %b want 1", Stall); end
    ok = 1;
    for (int j = 0; j < 3; j++) begin
      step();
      if (MemReq !== 1 || MemWE !== 0 || IValid !== 0) ok = 0;
    end
    total++; if (ok !== 1) begin bad++; $display("FAIL if_hold: got %b want 1", ok); end
    MemAck = 1; MemRData = 32'h0050_0093;
    step();
    MemAck = 0;
    total++; if (IValid !== 1 || IRData !== 32'h0050_0093) begin bad++; $display("FAIL if_done: got %b %h want 1 00500093", IValid, IRData); end
    total++; if (MemReq !== 0 || MemWE !== 0 || Stall !== 0) begin bad++; $display("FAIL if_after: got %b%b%b want 000", MemReq, MemWE, Stall); end
    IReq = 0;
    step();
    total++; if (IValid !== 0 || IRData !== 32'h0050_0093) begin bad++; $display("FAIL if_pulse: got %b %h want 0 00500093", IValid, IRData); end
  endtask

  task automatic test_store();
    logic ok;
    DReq = 1; DWE = 1; DAddr = 32'h0000_0100; DWData = 32'hCAFE_F00D;
    step();
    total++; if (MemReq !== 1 || MemWE !== 1 || MemAddr !== 32'h100 || MemWData !== 32'hCAFE_F00D) begin bad++; $display("FAIL st_req: got %b%b %h %h want 11 00000100 cafef00d", MemReq, MemWE, MemAddr, MemWData); end
    ok = 1;
    for (int j = 0; j < 2; j++) begin
      step();
      if (MemReq !== 1 || MemWE !== 1 || MemAddr !== 32'h100 || MemWData !== 32'hCAFE_F00D) ok = 0;
    end
    total++; if (ok !== 1) begin bad++; $display("FAIL st_hold: got %b want 1", ok); end
    MemAck = 1; MemRData = 32'hFFFF_FFFF;
    step();
    MemAck = 0;
    total++; if (DValid !== 1 || DRData !== '0 || IValid !== 0) begin bad++; $display("FAIL st_done: got %b %h %b want 1 00000000 0", DValid, DRData, IValid); end
    total++; if (MemReq !== 0) begin bad++; $display("FAIL st_memreq: got %b want 0", MemReq); end
    DReq = 0; DWE = 0;
    step();
    total++; if (DValid !== 0) begin bad++; $display("FAIL st_pulse: got %b want 0", DValid); end
  endtask

  task automatic test_tie();
    logic exp_d;
    do_reset();
    IReq = 1; IAddr = 32'h0000_1000;
    DReq = 1; DWE = 0; DAddr = 32'h0000_2000;
    exp_d = 1;
    for (int g = 0; g < 4; g++) begin
      step();
      total++; if (MemReq !== 1 || MemAddr !== (exp_d ? 32'h2000 : 32'h1000)) begin bad++; $display("FAIL tie_grant%0d: got %b %h want 1 %h", g, MemReq, MemAddr, exp_d ? 32'h2000 : 32'h1000); end
      MemAck = 1; MemRData = 32'h100 + g;
      step();
      MemAck = 0;
      total++; if ({IValid, DValid} !== (exp_d ? 2'b01 : 2'b10)) begin bad++; $display("FAIL tie_valid%0d: got %b want %b", g, {IValid, DValid}, exp_d ? 2'b01 : 2'b10); end
      exp_d = !exp_d;
    end
    IReq = 0; DReq = 0;
    step();
    total++; if ({MemReq, IValid, DValid} !== 3'b0) begin bad++; $display("FAIL tie_end: got %b want 000", {MemReq, IValid, DValid}); end
  endtask

  // Ack arrives on the last busy cycle before the abort would fire.
  task automatic test_boundary();
    logic ok;
    DReq = 1; DWE = 0; DAddr = 32'h0000_0040;
    step();
    ok = 1;
    for (int j = 0; j < TO - 1; j++) begin
      if (MemReq !== 1 || DValid !== 0) ok = 0;
      step();
    end
    total++; if (ok !== 1 || MemReq !== 1) begin bad++; $display("FAIL bnd_busy: got %b%b want 11", ok, MemReq); end
    MemAck = 1; MemRData = 32'h1234_5678;
    step();
    MemAck = 0;
    total++; if (DValid !== 1 || DRData !== 32'h1234_5678 || MemErr !== 0) begin bad++; $display("FAIL bnd_done: got %b %h %b want 1 12345678 0", DValid, DRData, MemErr); end
    DReq = 0;
    step();
  endtask

  task automatic test_timeout();
    int busy;
    DReq = 1; DWE = 0; DAddr = 32'h0000_0080; MemRData = 32'hAAAA_5555;
    step();
    busy = 0;
    for (int j = 0; j < 40 && MemReq === 1; j++) begin
      busy++;
      step();
    end
    total++; if (busy !== TO) begin bad++; $display("FAIL to_cycles: got %0d want %0d", busy, TO); end
    total++; if (DValid !== 1 || DRData !== '0 || MemReq !== 0) begin bad++; $display("FAIL to_done: got %b %h %b want 1 00000000 0", DValid, DRData, MemReq); end
    total++; if (MemErr !== 1) begin bad++; $display("FAIL to_err: got %b want 1", MemErr); end
    DReq = 0;
    for (int j = 0; j < 10; j++) step();
    total++; if (MemErr !== 1 || DValid !== 0) begin bad++; $display("FAIL to_sticky: got %b%b want 10", MemErr, DValid); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    IReq = 1; IAddr = 32'h0000_0200;
    step();
    step();
    total++; if (MemReq !== 1) begin bad++; $display("FAIL rm_busy: got %b want 1", MemReq); end
    #2;
    RST = 1;
    #1;
    total++; if (MemReq !== 0 || IValid !== 0 || MemErr !== 0) begin bad++; $display("FAIL rm_async: got %b%b%b want 000", MemReq, IValid, MemErr); end
    seen = IValid;
    step();
    seen |= IValid;
    RST = 0;
    IAddr = 32'h0000_0204;
    step();
    seen |= IValid;
    total++; if (seen !== 0) begin bad++; $display("FAIL rm_novalid: got %b want 0", seen); end
    total++; if (MemReq !== 1 || MemAddr !== 32'h204) begin bad++; $display("FAIL rm_newreq: got %b %h want 1 00000204", MemReq, MemAddr); end
    MemAck = 1; MemRData = 32'h0000_0013;
    step();
    MemAck = 0;
    total++; if (IValid !== 1 || IRData !== 32'h13) begin bad++; $display("FAIL rm_done: got %b %h want 1 00000013", IValid, IRData); end
    IReq = 0;
    step();
  endtask

  // Transaction-level model: alternating tie-break, ack delay k versus the
  // TIMEOUT budget decides data and error, and the other port's data holds.
  task automatic test_random();
    logic i_pend, d_pend, last_d, err, gd, to, ok, exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd, rd, exp_rd, i_data, d_data;
    int k;
    do_reset();
    i_pend = 0; d_pend = 0; last_d = 0; err = 0; i_data = '0; d_data = '0;
    for (int t = 0; t < 60; t++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1; IReq = 1; IAddr = $urandom;
      end
      if (!d_pend && ($urandom_range(0, 1) == 1 || !i_pend)) begin
        d_pend = 1; DReq = 1; DWE = 1'($urandom_range(0, 1)); DAddr = $urandom; DWData = $urandom;
      end
      gd = d_pend && (!i_pend || !last_d);
      last_d = gd;
      exp_addr = gd ? DAddr : IAddr;
      exp_we = gd ? DWE : 1'b0;
      exp_wd = DWData;
      step();
      total++; if (IValid !== 0 || DValid !== 0) begin bad++; $display("FAIL rnd%0d_pulse: got %b%b want 00", t, IValid, DValid); end
      total++; if (MemReq !== 1 || MemAddr !== exp_addr || MemWE !== exp_we || (gd && MemWData !== exp_wd)) begin bad++; $display("FAIL rnd%0d_grant: got %b%b %h %h want 1%b %h %h", t, MemReq, MemWE, MemAddr, MemWData, exp_we, exp_addr, exp_wd); end
      total++; if (Stall !== 1) begin bad++; $display("FAIL rnd%0d_stall_busy: got %b want 1", t, Stall); end
      k = $urandom_range(0, TO + 2);
      rd = $urandom;
      ok = 1;
      for (int j = 0; j < TO + 5; j++) begin
        MemAck = (j == k);
        MemRData = (j == k) ? rd : DW'($urandom);
        step();
        MemAck = 0;
        if (j == k || j == TO - 1) break;
        if (MemReq !== 1 || MemAddr !== exp_addr || MemWE !== exp_we || IValid !== 0 || DValid !== 0) ok = 0;
      end
      total++; if (ok !== 1) begin bad++; $display("FAIL rnd%0d_hold: got %b want 1", t, ok); end
      to = (k > TO - 1);
      err = err | to;
      exp_rd = (to || (gd && exp_we)) ? '0 : rd;
      if (gd) d_data = exp_rd; else i_data = exp_rd;
      total++; if ({IValid, DValid} !== (gd ? 2'b01 : 2'b10) || MemReq !== 0) begin bad++; $display("FAIL rnd%0d_valid: got %b%b%b want %b0", t, IValid, DValid, MemReq, gd ? 2'b01 : 2'b10); end
      total++; if (IRData !== i_data || DRData !== d_data) begin bad++; $display("FAIL rnd%0d_rdata: got %h/%h want %h/%h", t, IRData, DRData, i_data, d_data); end
      total++; if (MemErr !== err) begin bad++; $display("FAIL rnd%0d_err: got %b want %b", t, MemErr, err); end
      total++; if (Stall !== (gd ? i_pend : d_pend)) begin bad++; $display("FAIL rnd%0d_stall: got %b want %b", t, Stall, gd ? i_pend : d_pend); end
      if (gd) begin d_pend = 0; DReq = 0; end
      else begin i_pend = 0; IReq = 0; end
    end
    IReq = 0; DReq = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_ack_idle();
    test_ifetch();
    test_store();
    test_tie();
    test_boundary();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
